// File: rtl/i2s_mic_rx.sv
// ============================================================================
// i2s_mic_rx
//   Receiver for a single I2S MEMS microphone. The block is the I2S master:
//   it generates the bit clock (i2s_bclk) and word select (i2s_ws) from the
//   system clock. It captures one 18-bit two's-complement sample per frame
//   from the selected slot and presents it on data/data_rdy.
//
//   Frame layout: 64 BCLKs per frame. ws is low for bit indices 0..31 (left)
//   and high for 32..63 (right). Inside a slot, position 0 is the I2S
//   one-bit delay, 1..18 carry MSB..LSB, and 19..31 are ignored.
//
//   Output semantics: data/data_rdy carry no backpressure. data_rdy is high
//   for exactly one clock when data takes a new sample. data holds its value
//   at all other times. The consumer must take the sample in that clock.
//
//   Optional feature: define I2S_CLIP_DETECT_EN to build the sticky
//   full-scale (clip) detector. When it is undefined, clip is tied low and
//   no comparison logic is built.
// ============================================================================
module i2s_mic_rx #(
    parameter int CLK_DIV     = 16,  // clocks per BCLK half-period, 4..255
    parameter int CHANNEL     = 0,   // 0 = left (ws low), 1 = right (ws high)
    parameter int SKIP_FRAMES = 2    // whole frames discarded after reset
) (
    input  logic        clock,
    input  logic        reset,       // asynchronous, active low
    input  logic        i2s_sd,
    output logic        i2s_bclk,
    output logic        i2s_ws,
    output logic [17:0] data,
    output logic        data_rdy,
    output logic        clip
);

    // Skip counter only needs to reach SKIP_FRAMES; keep at least one bit.
    localparam int SKIP_W = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [7:0]        DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST  = SKIP_W'(SKIP_FRAMES);
    localparam logic              CHAN_SEL   = CHANNEL[0];

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [7:0]        r_div;     // divider, 0..CLK_DIV-1
    logic              r_bclk;    // internal bit clock (drives i2s_bclk)
    logic [5:0]        r_idx;     // bit index within the 64-bit frame
    logic              r_ws;      // word select, mirrors r_idx[5]
    logic              r_sd_q;    // sd sampled every clock
    logic [17:0]       r_shift;   // sample being assembled, MSB first
    logic              r_pend;    // LSB just captured, word complete
    logic [SKIP_W-1:0] r_skip;    // completed words thrown away so far
    logic [17:0]       r_data;
    logic              r_rdy;

    // ------------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------------
    logic       w_div_tc;     // divider at terminal count this clock
    logic       w_rise;       // internal bclk goes 0->1 at this edge
    logic       w_fall;       // internal bclk goes 1->0 at this edge
    logic [5:0] w_idx_next;
    logic [4:0] w_slot;       // position within the current slot
    logic       w_chan_hit;   // current slot is the forwarded one
    logic       w_in_window;  // slot position carries a data bit
    logic       w_capture;    // take r_sd_q into the shift register
    logic       w_last;       // this capture is the LSB (s = 18)
    logic       w_skip_done;  // skip period is over, words are presented

    assign w_div_tc    = (r_div == DIV_LAST);
    assign w_rise      = w_div_tc & ~r_bclk;
    assign w_fall      = w_div_tc &  r_bclk;
    assign w_idx_next  = r_idx + 6'd1;
    assign w_slot      = r_idx[4:0];
    assign w_chan_hit  = (r_idx[5] == CHAN_SEL);
    assign w_in_window = (w_slot >= 5'd1) && (w_slot <= 5'd18);
    assign w_capture   = w_rise & w_chan_hit & w_in_window;
    assign w_last      = w_capture & (w_slot == 5'd18);
    assign w_skip_done = (r_skip == SKIP_LAST);

    // ------------------------------------------------------------------------
    // Divider: wrap at terminal count and toggle the bit clock there, so the
    // first bclk rise comes CLK_DIV clocks after reset release.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div  <= 8'd0;
            r_bclk <= 1'b0;
        end else if (w_div_tc) begin
            r_div  <= 8'd0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame position: advance the bit index and ws on each bclk falling
    // event. The microphone shifts out new data on that same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx <= 6'd0;
            r_ws  <= 1'b0;
        end else if (w_fall) begin
            r_idx <= w_idx_next;
            r_ws  <= w_idx_next[5];
        end
    end

    // ------------------------------------------------------------------------
    // Serial data input register. It also keeps the capture path off the
    // pin directly.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sd_q <= 1'b0;
        end else begin
            r_sd_q <= i2s_sd;
        end
    end

    // ------------------------------------------------------------------------
    // Capture: shift in one bit per bclk rise inside the data window of the
    // selected slot. Flag a complete word after the LSB.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= 18'd0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= w_last;
            if (w_capture) begin
                r_shift <= {r_shift[16:0], r_sd_q};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Presentation: one clock after the LSB, either publish the word with a
    // strobe or use it up as a skipped frame. The skip counter stops at
    // SKIP_FRAMES, and only reset clears it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= 18'd0;
            r_rdy  <= 1'b0;
            r_skip <= '0;
        end else begin
            r_rdy <= 1'b0;
            if (r_pend) begin
                if (w_skip_done) begin
                    r_data <= r_shift;
                    r_rdy  <= 1'b1;
                end else begin
                    r_skip <= r_skip + SKIP_W'(1);
                end
            end
        end
    end

    assign i2s_bclk = r_bclk;
    assign i2s_ws   = r_ws;
    assign data     = r_data;
    assign data_rdy = r_rdy;

`ifdef I2S_CLIP_DETECT_EN
    logic w_full_scale;
    logic r_clip;

    // A word at either full-scale code counts as clipped.
    assign w_full_scale = (r_shift == 18'h1FFFF) || (r_shift == 18'h20000);

    // Sticky clip flag: it sets with the strobe that presents a full-scale
    // word and stays set until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clip <= 1'b0;
        end else if (r_pend && w_skip_done && w_full_scale) begin
            r_clip <= 1'b1;
        end
    end

    assign clip = r_clip;
`else
    assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// ============================================================================
// tb_i2s_mic_rx
//   Directed bench for i2s_mic_rx with CLK_DIV=4. Three instances share the
//   clock and reset:
//     u_c0 : CHANNEL=0, SKIP_FRAMES=0  (fed from word table A)
//     u_c1 : CHANNEL=1, SKIP_FRAMES=0  (fed from word table A)
//     u_sk : CHANNEL=0, SKIP_FRAMES=2  (fed from word table B)
//   A microphone model follows the generated bclk. It counts bclk falls to
//   track the frame position and drives MSB-first words. It drives random
//   bits at positions that must be ignored.
// ============================================================================
module tb_i2s_mic_rx;

    localparam int DIV = 4;
`ifdef I2S_CLIP_DETECT_EN
    localparam logic CLIP_EXP = 1'b1;
`else
    localparam logic CLIP_EXP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT wiring ----------------
    logic        sd_a = 1'b0;
    logic        sd_b = 1'b0;
    logic        bclk_c0, ws_c0, rdy_c0, clip_c0;
    logic        bclk_c1, ws_c1, rdy_c1, clip_c1;
    logic        bclk_sk, ws_sk, rdy_sk, clip_sk;
    logic [17:0] data_c0, data_c1, data_sk;

    i2s_mic_rx #(.CLK_DIV(DIV), .CHANNEL(0), .SKIP_FRAMES(0)) u_c0 (
        .clock(clock), .reset(reset), .i2s_sd(sd_a),
        .i2s_bclk(bclk_c0), .i2s_ws(ws_c0),
        .data(data_c0), .data_rdy(rdy_c0), .clip(clip_c0));

    i2s_mic_rx #(.CLK_DIV(DIV), .CHANNEL(1), .SKIP_FRAMES(0)) u_c1 (
        .clock(clock), .reset(reset), .i2s_sd(sd_a),
        .i2s_bclk(bclk_c1), .i2s_ws(ws_c1),
        .data(data_c1), .data_rdy(rdy_c1), .clip(clip_c1));

    i2s_mic_rx #(.CLK_DIV(DIV), .CHANNEL(0), .SKIP_FRAMES(2)) u_sk (
        .clock(clock), .reset(reset), .i2s_sd(sd_b),
        .i2s_bclk(bclk_sk), .i2s_ws(ws_sk),
        .data(data_sk), .data_rdy(rdy_sk), .clip(clip_sk));

    // ---------------- word tables (indexed by frame) ----------------
    logic [17:0] lw_a [0:7];
    logic [17:0] rw_a [0:7];
    logic [17:0] lw_b [0:7];
    logic [17:0] rw_b [0:7];

    // ---------------- microphone model ----------------
    logic [5:0] mcnt = 6'd0;
    int         mfrm = 0;

    always @(negedge bclk_c0 or negedge reset) begin
        if (!reset) begin
            mcnt = 6'd0;
            mfrm = 0;
            sd_a = 1'b0;
            sd_b = 1'b0;
        end else begin
            int          bitn;
            logic [17:0] wa;
            logic [17:0] wb;
            mcnt = mcnt + 6'd1;
            if (mcnt == 6'd0 && mfrm < 7) mfrm = mfrm + 1;
            wa = mcnt[5] ? rw_a[mfrm] : lw_a[mfrm];
            wb = mcnt[5] ? rw_b[mfrm] : lw_b[mfrm];
            if (mcnt[4:0] >= 5'd1 && mcnt[4:0] <= 5'd18) begin
                bitn = 18 - int'(mcnt[4:0]);
                sd_a = wa[bitn];
                sd_b = wb[bitn];
            end else begin
                sd_a = 1'($urandom_range(0, 1));
                sd_b = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- strobe monitor ----------------
    int          n0 = 0, n1 = 0, nsk = 0;
    logic [17:0] last0 = '0, last1 = '0, lastsk = '0;
    logic        bad0 = 1'b0, bad1 = 1'b0;

    always @(negedge clock) begin
        if (rdy_c0) begin
            n0 = n0 + 1;
            last0 = data_c0;
            if (data_c0 == 18'h15A5A) bad0 = 1'b1;
        end
        if (rdy_c1) begin
            n1 = n1 + 1;
            last1 = data_c1;
            if (data_c1 == 18'h2A5A5) bad1 = 1'b1;
        end
        if (rdy_sk) begin
            nsk = nsk + 1;
            lastsk = data_sk;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the next u_c0 strobe. The wait is bounded. Also return clip
    // as it was one clock before the strobe.
    task automatic wait_rdy0(output logic found, output logic prev_clip);
        found     = 1'b0;
        prev_clip = 1'b0;
        for (int i = 0; i < 700; i++) begin
            prev_clip = clip_c0;
            @(negedge clock);
            if (rdy_c0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   first_rise, ws_rise1, ws_rise2;
        int   b0, b1, bsk;
        logic prev_ws, found, pclip;

        // Phase A tables
        for (int i = 0; i < 8; i++) begin
            lw_a[i] = 18'h2A5A5;
            rw_a[i] = 18'h15A5A;
            lw_b[i] = 18'(i + 1);
            rw_b[i] = 18'h3FFFF;
        end

        // Reset held low for 10 cycles
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("rst_bclk", 32'(bclk_c0), 32'd0);
        chk("rst_ws", 32'(ws_c0), 32'd0);
        chk("rst_data", 32'(data_c0), 32'd0);
        chk("rst_rdy", 32'(rdy_c0), 32'd0);
        chk("rst_clip", 32'(clip_c0), 32'd0);

        // Release and watch bclk/ws timing plus four frames of capture
        reset = 1'b1;
        b0 = n0; b1 = n1; bsk = nsk;
        first_rise = 0; ws_rise1 = 0; ws_rise2 = 0; prev_ws = 1'b0;
        for (int k = 1; k <= 2100; k++) begin
            @(posedge clock);
            #1;
            if (bclk_c0 && first_rise == 0) first_rise = k;
            if (ws_c0 && !prev_ws) begin
                if (ws_rise1 == 0) ws_rise1 = k;
                else if (ws_rise2 == 0) ws_rise2 = k;
            end
            prev_ws = ws_c0;
            if (k == 1000) begin
                chk("skip_no_early_rdy", 32'(nsk - bsk), 32'd0);
                chk("skip_data_still_0", 32'(data_sk), 32'd0);
                chk("c0_data_hold", 32'(data_c0), 32'h2A5A5);
            end
        end
        chk("first_bclk_rise", 32'(first_rise), 32'd4);
        chk("first_ws_rise", 32'(ws_rise1), 32'd256);
        chk("ws_period", 32'(ws_rise2 - ws_rise1), 32'd512);
        chk("c0_rdy_count", 32'(n0 - b0), 32'd4);
        chk("c0_data", 32'(last0), 32'h2A5A5);
        chk("c0_no_right_word", 32'(bad0), 32'd0);
        chk("c1_rdy_count", 32'(n1 - b1), 32'd4);
        chk("c1_data", 32'(last1), 32'h15A5A);
        chk("c1_no_left_word", 32'(bad1), 32'd0);
        chk("skip_rdy_count", 32'(nsk - bsk), 32'd2);
        chk("skip_data", 32'(lastsk), 32'd4);

        // Phase B: assert reset at bit index 10 of the left slot
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (mcnt == 6'd10 && bclk_c0) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_index_10", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_bclk", 32'(bclk_c0), 32'd0);
        chk("mid_rst_ws", 32'(ws_c0), 32'd0);
        chk("mid_rst_data_c0", 32'(data_c0), 32'd0);
        chk("mid_rst_data_c1", 32'(data_c1), 32'd0);
        chk("mid_rst_data_sk", 32'(data_sk), 32'd0);
        chk("mid_rst_rdy", 32'(rdy_c0), 32'd0);
        chk("mid_rst_clip", 32'(clip_c0), 32'd0);

        for (int i = 0; i < 8; i++) begin
            lw_a[i] = 18'h00000;
            rw_a[i] = 18'h20000;
            lw_b[i] = 18'(i + 5);
        end
        lw_a[0] = 18'h00010;
        lw_a[1] = 18'h1FFFF;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        b0 = n0; b1 = n1; bsk = nsk;

        wait_rdy0(found, pclip);
        chk("strobe1_seen", 32'(found), 32'd1);
        chk("strobe1_data", 32'(data_c0), 32'h00010);
        chk("strobe1_clip", 32'(clip_c0), 32'd0);

        wait_rdy0(found, pclip);
        chk("strobe2_seen", 32'(found), 32'd1);
        chk("strobe2_data", 32'(data_c0), 32'h1FFFF);
        chk("strobe2_clip_before", 32'(pclip), 32'd0);
        chk("strobe2_clip", 32'(clip_c0), 32'(CLIP_EXP));
        chk("skip_rearmed", 32'(nsk - bsk), 32'd0);

        wait_rdy0(found, pclip);
        chk("strobe3_seen", 32'(found), 32'd1);
        chk("strobe3_data", 32'(data_c0), 32'h00000);
        chk("strobe3_clip_sticky", 32'(clip_c0), 32'(CLIP_EXP));

        repeat (5) @(negedge clock);
        chk("c0_b_rdy_count", 32'(n0 - b0), 32'd3);
        chk("skip_b_rdy_count", 32'(nsk - bsk), 32'd1);
        chk("skip_b_data", 32'(lastsk), 32'd7);
        chk("c1_b_data", 32'(last1), 32'h20000);
        chk("c1_clip_neg_full", 32'(clip_c1), 32'(CLIP_EXP));
        chk("skip_clip", 32'(clip_sk), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
